// File: rtl/d2l_pkg.sv
// Shared states, constants and frame arithmetic for the d2l serial link.
// Parity framing is enabled by defining D2L_PARITY_EN.
package d2l_pkg;
  localparam int   LEN_W      = 8;
  localparam logic LANE_START = 1'b0;
  localparam logic LANE_STOP  = 1'b1;

`ifdef D2L_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_LEN, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_LEN, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

  function automatic int frame_cycles(input int len, input int lanes, input bit par);
    return 2 + LEN_W / lanes + (len * 8) / lanes + (par ? 1 : 0);
  endfunction

  function automatic logic [15:0] data_cycles(input logic [LEN_W-1:0] len, input int lanes);
    return 16'(({8'd0, len} << 3) / lanes);
  endfunction
endpackage

// File: rtl/d2l_lane_rx.sv
// Frame deserializer: out_valid one edge after the STOP sample; no backpressure, results held until next frame.
module d2l_lane_rx
  import d2l_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int LANES  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LANES-1:0]  rx_lane,
  output logic              out_valid,
  output logic [LEN_W-1:0]  out_len,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);
  localparam logic [LEN_W-1:0] MAX_BYTES = LEN_W'(DATA_W / 8);
  localparam logic [15:0]      LEN_LAST  = 16'(LEN_W / LANES - 1);
  localparam int               LANE_SH   = $clog2(LANES);

  rx_state_t         r_state, w_next, w_tail;
  logic [15:0]       r_cnt, r_dcyc;
  logic [LEN_W-1:0]  r_len_sh, w_len;
  logic [DATA_W-1:0] r_buf;
  logic              r_par, r_err;

  // Length arrives LSB first, so each new slice enters at the top
  assign w_len = (r_len_sh >> LANES) | (LEN_W'(rx_lane) << (LEN_W - LANES));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RX_IDLE;
      r_cnt     <= '0;
      r_dcyc    <= '0;
      r_len_sh  <= '0;
      r_buf     <= '0;
      r_par     <= 1'b0;
      r_err     <= 1'b0;
      out_valid <= 1'b0;
      out_len   <= '0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else begin
      r_state   <= w_next;
      out_valid <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_cnt    <= '0;
          r_len_sh <= '0;
          r_buf    <= '0;
          r_par    <= 1'b0;
          r_err    <= 1'b0;
        end
        RX_LEN: begin
          r_len_sh <= w_len;
          r_par    <= r_par ^ (^rx_lane);
          r_cnt    <= r_cnt + 16'd1;
          if (r_cnt == LEN_LAST) begin
            r_cnt  <= '0;
            r_dcyc <= data_cycles(w_len, LANES);
            r_err  <= (w_len > MAX_BYTES);
          end
        end
        RX_DATA: begin
          // Slices past DATA_W shift out to zero, so oversize frames keep only the first bytes
          r_buf <= r_buf | (DATA_W'(rx_lane) << (r_cnt << LANE_SH));
          r_par <= r_par ^ (^rx_lane);
          r_cnt <= r_cnt + 16'd1;
        end
        RX_PAR: begin
          if (rx_lane[0] != r_par) r_err <= 1'b1;
        end
        RX_STOP: begin
          out_valid <= 1'b1;
          out_len   <= r_len_sh;
          out_data  <= r_buf;
          out_err   <= r_err | (rx_lane != {LANES{LANE_STOP}});
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_tail = RX_STOP;
    if (PAR_EN) w_tail = RX_PAR;
    w_next = r_state;
    case (r_state)
      RX_IDLE: if (rx_lane[0] == LANE_START) w_next = RX_LEN;
      RX_LEN: begin
        if (r_cnt == LEN_LAST) begin
          if (w_len != '0) w_next = RX_DATA;
          else             w_next = w_tail;
        end
      end
      RX_DATA: if (r_cnt == r_dcyc - 16'd1) w_next = w_tail;
      RX_PAR:  w_next = RX_STOP;
      RX_STOP: w_next = RX_IDLE;
      default: w_next = RX_IDLE;
    endcase
  end
endmodule

// File: rtl/d2l_link.sv
// Framed multi-lane serial link (TX serializer + d2l_lane_rx); D2L_PARITY_EN adds a parity cycle.
// Loopback latency is F edges from acceptance to out_valid; in_ready is low while a frame is in flight.
module d2l_link
  import d2l_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int LANES  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LEN_W-1:0]  in_len,
  input  logic [DATA_W-1:0] in_data,
  output logic [LANES-1:0]  tx_lane,
  input  logic [LANES-1:0]  rx_lane,
  output logic              out_valid,
  output logic [LEN_W-1:0]  out_len,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);
  localparam logic [LEN_W-1:0] MAX_BYTES = LEN_W'(DATA_W / 8);
  localparam logic [15:0]      LEN_LAST  = 16'(LEN_W / LANES - 1);

  tx_state_t         r_state, w_next, w_tail;
  logic [15:0]       r_cnt, r_dcyc;
  logic [LEN_W-1:0]  r_len_sh, w_len_clamp;
  logic [DATA_W-1:0] r_data_sh;
  logic              r_par;

  assign w_len_clamp = (in_len > MAX_BYTES) ? MAX_BYTES : in_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= TX_IDLE;
      r_cnt     <= '0;
      r_dcyc    <= '0;
      r_len_sh  <= '0;
      r_data_sh <= '0;
      r_par     <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        TX_IDLE: begin
          if (in_valid) begin
            r_len_sh  <= w_len_clamp;
            r_data_sh <= in_data;
            r_dcyc    <= data_cycles(w_len_clamp, LANES);
            r_par     <= 1'b0;
          end
        end
        TX_START: r_cnt <= '0;
        TX_LEN: begin
          r_len_sh <= r_len_sh >> LANES;
          r_par    <= r_par ^ (^r_len_sh[LANES-1:0]);
          r_cnt    <= (r_cnt == LEN_LAST) ? 16'd0 : r_cnt + 16'd1;
        end
        TX_DATA: begin
          r_data_sh <= r_data_sh >> LANES;
          r_par     <= r_par ^ (^r_data_sh[LANES-1:0]);
          r_cnt     <= r_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_tail = TX_STOP;
    if (PAR_EN) w_tail = TX_PAR;
    w_next   = r_state;
    tx_lane  = {LANES{LANE_STOP}};
    in_ready = 1'b0;
    case (r_state)
      TX_IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) w_next = TX_START;
      end
      TX_START: begin
        tx_lane = {LANES{LANE_START}};
        w_next  = TX_LEN;
      end
      TX_LEN: begin
        tx_lane = r_len_sh[LANES-1:0];
        if (r_cnt == LEN_LAST) begin
          if (r_dcyc != 16'd0) w_next = TX_DATA;
          else                 w_next = w_tail;
        end
      end
      TX_DATA: begin
        tx_lane = r_data_sh[LANES-1:0];
        if (r_cnt == r_dcyc - 16'd1) w_next = w_tail;
      end
      TX_PAR: begin
        tx_lane[0] = r_par;
        w_next     = TX_STOP;
      end
      TX_STOP: w_next = TX_IDLE;
      default: w_next = TX_IDLE;
    endcase
    // Lanes go idle as soon as reset is seen, even before the state register clears
    if (rst) tx_lane = {LANES{LANE_STOP}};
  end

  d2l_lane_rx #(
    .DATA_W(DATA_W),
    .LANES (LANES)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx_lane  (rx_lane),
    .out_valid(out_valid),
    .out_len  (out_len),
    .out_data (out_data),
    .out_err  (out_err)
  );
endmodule

// File: tb/tb_d2l_link.sv
// Loopback bench for d2l_link: 1-lane and 4-lane instances, directed and random frames vs a bit-stream model.
module tb_d2l_link;
`ifdef D2L_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, v1, v4, rdy1, rdy4;
  logic [7:0]  in_len;
  logic [63:0] in_data;
  logic [0:0]  tx1, rx1;
  logic [3:0]  tx4, rx4;
  logic        ov1, ov4, err1, err4;
  logic [7:0]  ol1, ol4;
  logic [63:0] od1, od4;
  logic        frc1 = 1'b0, frc4 = 1'b0, flp1 = 1'b0, flp4 = 1'b0;
  logic        man_en = 1'b0, man_bit = 1'b1;
  bit          sel = 1'b0;

  assign rx1 = man_en ? man_bit : (frc1 ? 1'b0 : (tx1 ^ flp1));
  assign rx4 = frc4 ? 4'h0 : (tx4 ^ {3'b000, flp4});

  d2l_link #(.DATA_W(64), .LANES(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_len(in_len), .in_data(in_data),
    .tx_lane(tx1), .rx_lane(rx1), .out_valid(ov1), .out_len(ol1), .out_data(od1), .out_err(err1));

  d2l_link #(.DATA_W(64), .LANES(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .in_len(in_len), .in_data(in_data),
    .tx_lane(tx4), .rx_lane(rx4), .out_valid(ov4), .out_len(ol4), .out_data(od4), .out_err(err4));

  logic        s_rdy, s_ov, s_err;
  logic [7:0]  s_len, s_tx;
  logic [63:0] s_data;
  assign s_rdy  = sel ? rdy4 : rdy1;
  assign s_ov   = sel ? ov4 : ov1;
  assign s_err  = sel ? err4 : err1;
  assign s_len  = sel ? ol4 : ol1;
  assign s_data = sel ? od4 : od1;
  assign s_tx   = sel ? {4'h0, tx4} : {7'h0, tx1};

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int f_of(int lanes, int clen);
    return 2 + 8 / lanes + clen * 8 / lanes + PAR;
  endfunction

  function automatic logic [63:0] keep(logic [63:0] d, int nbytes);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < nbytes && i < 8; i++) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  // Expected lane vector during the c-th cycle after acceptance
  function automatic logic [7:0] exp_tx(int lanes, int c, int clen, logic [63:0] d);
    logic [71:0] stream;
    logic [7:0]  v;
    int          nl, nd, p;
    stream = {d, 8'(clen)};
    nl = 8 / lanes;
    nd = clen * 8 / lanes;
    p  = 0;
    for (int b = 0; b < 8 + clen * 8; b++) p = p ^ int'(stream[b]);
    v = 8'((1 << lanes) - 1);
    if (c == 1) v = 8'h00;
    else if (c <= 1 + nl + nd) begin
      for (int k = 0; k < lanes; k++) v[k] = stream[(c - 2) * lanes + k];
    end else if (PAR == 1 && c == 2 + nl + nd) v[0] = p[0];
    return v;
  endfunction

  // mode: 0 clean, 1 corrupt STOP on rx, 2 flip first DATA bit on rx, 3 reset pulse mid-DATA
  task automatic send(input bit s, input int len, input logic [63:0] d, input int mode,
                      output int got_f, output logic [7:0] g_len, output logic [63:0] g_data,
                      output logic g_err);
    int clen, lanes, f, nl, n, rst_e, bad;
    sel   = s;
    lanes = s ? 4 : 1;
    clen  = (len > 8) ? 8 : len;
    nl    = 8 / lanes;
    f     = f_of(lanes, clen);
    rst_e = 3 + nl;
    @(negedge clk);
    in_len  = 8'(len);
    in_data = d;
    n = 0;
    while (!s_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 64'(s_rdy), 64'd1);
    if (s) v4 = 1'b1; else v1 = 1'b1;
    @(posedge clk);
    #1;
    v1 = 1'b0;
    v4 = 1'b0;
    in_len  = 8'($urandom);
    in_data = {$urandom, $urandom};
    got_f = -1; bad = 0; g_len = '0; g_data = '0; g_err = 1'b0;
    for (int e = 1; e <= f + 3 && got_f < 0; e++) begin
      @(negedge clk);
      if (mode != 3 || e <= rst_e) begin
        if (s_tx !== exp_tx(lanes, e, clen, d)) bad++;
      end
      if (mode == 3 && e == rst_e + 1) begin
        chk("tx_idle_after_rst", 64'(s_tx), 64'((1 << lanes) - 1));
        chk("ready_low_in_rst", 64'(s_rdy), 64'd0);
      end
      if (s) begin
        frc4 = (mode == 1 && e == f);
        flp4 = (mode == 2 && e == 2 + nl);
      end else begin
        frc1 = (mode == 1 && e == f);
        flp1 = (mode == 2 && e == 2 + nl);
      end
      rst = (mode == 3 && e == rst_e);
      @(posedge clk);
      #1;
      if (s_ov) begin
        got_f  = e;
        g_len  = s_len;
        g_data = s_data;
        g_err  = s_err;
      end
    end
    frc1 = 1'b0; frc4 = 1'b0; flp1 = 1'b0; flp4 = 1'b0; rst = 1'b0;
    chk("tx_wave", 64'(bad), 64'd0);
  endtask

  initial begin
    int          gf, len, clen;
    logic [7:0]  gl;
    logic [63:0] gd, d;
    logic        ge;
    logic [87:0] mstream;
    logic [79:0] mdat;

    rst = 1'b1; v1 = 1'b0; v4 = 1'b0; in_len = '0; in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx1", 64'(tx1), 64'h1);
    chk("rst_tx4", 64'(tx4), 64'hF);
    chk("rst_rdy1", 64'(rdy1), 64'd0);
    chk("rst_rdy4", 64'(rdy4), 64'd0);
    chk("rst_ov1", 64'(ov1), 64'd0);
    chk("rst_err1", 64'(err1), 64'd0);
    chk("rst_len1", 64'(ol1), 64'd0);
    chk("rst_data1", od1, 64'd0);
    chk("rst_ov4", 64'(ov4), 64'd0);
    chk("rst_data4", od4, 64'd0);
    rst = 1'b0;

    send(1'b0, 8, 64'h9F3A7C21BD845E62, 0, gf, gl, gd, ge);
    chk("d1_latency", 64'(gf), 64'(74 + PAR));
    chk("d1_data", gd, 64'h9F3A7C21BD845E62);
    chk("d1_len", 64'(gl), 64'd8);
    chk("d1_err", 64'(ge), 64'd0);
    repeat (4) @(negedge clk);
    chk("hold_valid_pulse", 64'(ov1), 64'd0);
    chk("hold_data", od1, 64'h9F3A7C21BD845E62);
    chk("hold_len", 64'(ol1), 64'd8);

    send(1'b1, 3, 64'hC8D24F910A6BE357, 0, gf, gl, gd, ge);
    chk("d2_latency", 64'(gf), 64'(10 + PAR));
    chk("d2_data", gd, 64'h00000000006BE357);
    chk("d2_len", 64'(gl), 64'd3);
    chk("d2_err", 64'(ge), 64'd0);

    d = {$urandom, $urandom};
    send(1'b0, 200, d, 0, gf, gl, gd, ge);
    chk("clamp_len", 64'(gl), 64'd8);
    chk("clamp_data", gd, d);
    chk("clamp_err", 64'(ge), 64'd0);
    chk("clamp_latency", 64'(gf), 64'(74 + PAR));

    d = {$urandom, $urandom};
    send(1'b0, 5, d, 1, gf, gl, gd, ge);
    chk("stop_err_valid", 64'(gf), 64'(f_of(1, 5)));
    chk("stop_err_flag", 64'(ge), 64'd1);
    send(1'b0, 5, d, 0, gf, gl, gd, ge);
    chk("after_stop_err", 64'(ge), 64'd0);
    chk("after_stop_data", gd, keep(d, 5));

    d = {$urandom, $urandom};
    send(1'b0, 6, d, 3, gf, gl, gd, ge);
    chk("rst_abort_no_valid", 64'(gf), 64'(-1));
    send(1'b0, 6, d, 0, gf, gl, gd, ge);
    chk("after_rst_data", gd, keep(d, 6));
    chk("after_rst_err", 64'(ge), 64'd0);

`ifdef D2L_PARITY_EN
    d = {$urandom, $urandom};
    send(1'b0, 4, d, 2, gf, gl, gd, ge);
    chk("par_flip_err1", 64'(ge), 64'd1);
    send(1'b1, 4, d, 2, gf, gl, gd, ge);
    chk("par_flip_err4", 64'(ge), 64'd1);
`endif

    // Oversize length driven by hand on the 1-lane receiver
    sel = 1'b0;
    mdat = {$urandom, $urandom, 16'($urandom)};
    mstream = {mdat, 8'd10};
    @(negedge clk);
    man_en  = 1'b1;
    man_bit = 1'b0;
    for (int i = 0; i < 88; i++) begin
      @(negedge clk);
      man_bit = mstream[i];
    end
`ifdef D2L_PARITY_EN
    @(negedge clk);
    man_bit = ^mstream;
`endif
    @(negedge clk);
    man_bit = 1'b1;
    @(posedge clk);
    #1;
    chk("lenerr_valid", 64'(ov1), 64'd1);
    chk("lenerr_flag", 64'(err1), 64'd1);
    chk("lenerr_len", 64'(ol1), 64'd10);
    chk("lenerr_data", od1, mdat[63:0]);
    @(negedge clk);
    man_en = 1'b0;

    for (int i = 0; i < 12; i++) begin
      len  = $urandom_range(0, 12);
      clen = (len > 8) ? 8 : len;
      d    = {$urandom, $urandom};
      send(bit'(i % 2), len, d, 0, gf, gl, gd, ge);
      chk("rnd_latency", 64'(gf), 64'(f_of((i % 2 == 1) ? 4 : 1, clen)));
      chk("rnd_data", gd, keep(d, clen));
      chk("rnd_len", 64'(gl), 64'(clen));
      chk("rnd_err", 64'(ge), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/d2l_link.md
D2L_LINK -- requirements
Module: d2l_link

Interface
REQ-001 Parameter DATA_W, default 64, payload width in bits; SHALL be a multiple of 8, 8..256.
REQ-002 Parameter LANES, default 1, parallel serial lanes; SHALL be 1, 2, 4 or 8.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  source offers a frame.
REQ-006 in_ready  output  1  block can accept; a frame is accepted on a clk edge where in_valid and in_ready are both 1.
REQ-007 in_len  input  8  payload length in bytes.
REQ-008 in_data  input  DATA_W  payload, byte 0 in bits [7:0].
REQ-009 tx_lane  output  LANES  serial transmit lanes, idle all-ones.
REQ-010 rx_lane  input  LANES  serial receive lanes, same format as tx_lane.
REQ-011 out_valid  output  1  one-cycle pulse when a received frame is complete.
REQ-012 out_len  output  8  received byte count.
REQ-013 out_data  output  DATA_W  received payload; bytes at index out_len and above are zero.
REQ-014 out_err  output  1  error flag for the frame, qualified by out_valid.

Function
REQ-015 Clamping: in_len above DATA_W/8 SHALL be clamped to DATA_W/8 at acceptance; in_len 0 SHALL send a header-only frame.
REQ-016 Frame sequence on tx_lane:
- START: 1 cycle, all lanes 0.
- LEN: 8/LANES cycles carrying the clamped length, LSB first; lane k carries bit (i*LANES+k) in cycle i.
- DATA: len*8/LANES cycles carrying the payload, LSB first, same lane mapping.
- PAR: 1 cycle, present only when parity is enabled (REQ-029).
- STOP: 1 cycle, all lanes 1.
REQ-017 TX FSM states SHALL be IDLE, START, LEN, DATA, PAR, STOP, then return to IDLE.
REQ-018 in_ready SHALL be 1 only in TX IDLE and not in reset.
REQ-019 Inputs SHALL be registered at acceptance; in_data and in_len changes after acceptance SHALL have no effect.
REQ-020 Idle gap: at least one IDLE cycle (all lanes 1) SHALL separate STOP from the next START.
REQ-021 RX FSM states SHALL be IDLE, LEN, DATA, PAR, STOP.
- RX leaves IDLE when rx_lane[0] is sampled 0.
- RX ignores start conditions while not in IDLE.
- rx_lane is sampled every edge with no oversampling.
REQ-022 Frame length: F = 2 + 8/LANES + len*8/LANES (+1 with parity).
REQ-023 Latency: with rx_lane tied to tx_lane, out_valid SHALL be 1 in the cycle following the F-th clk edge after the accepting edge.
REQ-024 Framing error: a STOP sample that is not all-ones SHALL set out_err=1; out_valid SHALL still pulse, and RX SHALL return to IDLE.
REQ-025 Length error: a received length above DATA_W/8 SHALL set out_err=1; RX SHALL capture only DATA_W/8 bytes, out_len SHALL equal the received value, and RX SHALL return to IDLE.
REQ-026 Hold: out_data, out_len and out_err SHALL hold their values until the next out_valid.
REQ-027 Independence: TX and RX SHALL operate independently; a frame may be transmitted while another is being received.

Reset
REQ-028 While rst=1, the block SHALL hold:
- tx_lane all-ones, in_ready 0;
- out_valid 0, out_err 0, out_len 0, out_data 0;
- both FSMs in IDLE.
Mid-frame assertion of rst SHALL abort both FSMs in the next cycle, and no out_valid SHALL be generated for the aborted frame.

Configuration
REQ-029 Macro D2L_PARITY_EN defined:
- a PAR cycle is inserted after DATA;
- lane 0 carries even parity over the LEN and DATA bits, other lanes 1;
- a parity mismatch at RX sets out_err=1.
Macro undefined: no PAR cycle, and out_err reflects framing and length errors only.

Structure
REQ-030 Package d2l_pkg SHALL hold:
- TX and RX state enums;
- LEN_W=8 and the START/STOP lane constants;
- a function computing F from len, LANES and parity.
REQ-031 The receive path SHALL be sub-module d2l_lane_rx, instantiated once in d2l_link.

Verification
REQ-032 Bench ties rx_lane to tx_lane unless a scenario states otherwise. Directed scenarios:
- DATA_W=64, LANES=1, no parity; send len 8, data 64'h9F3A7C21BD845E62 -> out_valid after 74 edges; out_data equals input; out_err 0.
- LANES=4; send len 3, data 64'hC8D24F910A6BE357 -> out_data 64'h00000000006BE357, out_len 3, F=10.
- Send len 200 -> clamped to 8; out_len 8; full payload returned; out_err 0.
- Force rx_lane to 0 during the STOP cycle -> out_valid pulses with out_err 1; the next clean frame passes.
- Assert rst for 1 cycle mid-DATA -> tx_lane all-ones next cycle; no out_valid; a following frame passes.
- With D2L_PARITY_EN, flip one DATA bit on rx_lane -> out_err 1; unflipped frames -> out_err 0; F grows by 1.
